countdown_timer_ctrl: RTL

- Control FSM and BCD mm:ss down-counter for the kitchen-timer application on the clock library.
- Consumes a 1-cycle seconds enable pulse (`clk_sec`, produced by the existing usec/div-1000 divider chain) and single-cycle button pulses (already debounced and edge-detected).
- Sequences set → run → pause → alarm, and drives four BCD digits to the FND display driver plus an alarm output to the buzzer.

---
 rtl/timer_pkg.sv | 14 +
 rtl/bcd_mmss_counter.sv | 100 ++++++++++
 rtl/countdown_timer_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and BCD limits for the kitchen countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      ALARM = 2'd3
   } timer_state_e;

   localparam logic [3:0] SEC10_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD mm:ss register with set-increment, one-second decrement and clear.
module bcd_mmss_counter
   import timer_pkg::*;
#(
   parameter int MAX_MIN10 = 5
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       inc_min,
   input  logic       inc_sec,
   input  logic       dec,
   input  logic       clr,
   output logic [3:0] min10,
   output logic [3:0] min1,
   output logic [3:0] sec10,
   output logic [3:0] sec1,
   output logic       is_zero,
   output logic       is_one
);

   localparam logic [3:0] MIN10_MAX = 4'(MAX_MIN10);

   logic [3:0] min10_q, min1_q, sec10_q, sec1_q;
   logic [3:0] min10_d, min1_d, sec10_d, sec1_d;

   assign is_zero = (min10_q == 4'd0) && (min1_q == 4'd0) && (sec10_q == 4'd0) && (sec1_q == 4'd0);
   assign is_one  = (min10_q == 4'd0) && (min1_q == 4'd0) && (sec10_q == 4'd0) && (sec1_q == 4'd1);

   // Next digit values: clear wins, then decrement with borrow, then set increments.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      min10_d = min10_q;
      min1_d  = min1_q;
      sec10_d = sec10_q;
      sec1_d  = sec1_q;
      if (clr) begin
         min10_d = 4'd0;
         min1_d  = 4'd0;
         sec10_d = 4'd0;
         sec1_d  = 4'd0;
      end else if (dec && !is_zero) begin
         if (sec1_q != 4'd0) begin
            sec1_d = sec1_q - 4'd1;
         end else begin
            sec1_d = DIGIT_MAX;
            if (sec10_q != 4'd0) begin
               sec10_d = sec10_q - 4'd1;
            end else begin
               // Seconds were 00 and time is nonzero, so minutes are at least 01.
               sec10_d = SEC10_MAX;
               if (min1_q != 4'd0) begin
                  min1_d = min1_q - 4'd1;
               end else begin
                  min1_d  = DIGIT_MAX;
                  min10_d = min10_q - 4'd1;
               end
            end
         end
      end else begin
         if (inc_sec) begin
            if (sec1_q == DIGIT_MAX) begin
               sec1_d  = 4'd0;
               sec10_d = (sec10_q == SEC10_MAX) ? 4'd0 : sec10_q + 4'd1;
            end else begin
               sec1_d = sec1_q + 4'd1;
            end
         end
         if (inc_min) begin
            if (min1_q == DIGIT_MAX) begin
               min1_d  = 4'd0;
               min10_d = (min10_q == MIN10_MAX) ? 4'd0 : min10_q + 4'd1;
            end else begin
               min1_d = min1_q + 4'd1;
            end
         end
      end
   end

   // Digit registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset_p) begin
         min10_q <= 4'd0;
         min1_q  <= 4'd0;
         sec10_q <= 4'd0;
         sec1_q  <= 4'd0;
      end else begin
         min10_q <= min10_d;
         min1_q  <= min1_d;
         sec10_q <= sec10_d;
         sec1_q  <= sec1_d;
      end
   end

   assign min10 = min10_q;
   assign min1  = min1_q;
   assign sec10 = sec10_q;
   assign sec1  = sec1_q;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Kitchen-timer control FSM: set -> run -> pause -> alarm around a BCD mm:ss counter.
module countdown_timer_ctrl
   import timer_pkg::*;
#(
   parameter int ALARM_SEC = 10,
   parameter int MAX_MIN10 = 5
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       clk_sec,
   input  logic       btn_start,
   input  logic       btn_min,
   input  logic       btn_sec,
   input  logic       btn_clear,
   output logic [3:0] min10,
   output logic [3:0] min1,
   output logic [3:0] sec10,
   output logic [3:0] sec1,
   output logic       running,
   output logic       alarm,
   output logic       timeout
);

   localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC);

   timer_state_e state_q, state_d;
   logic [5:0]   alarm_cnt_q, alarm_cnt_d;
   logic         running_q, running_d;
   logic         alarm_q, alarm_d;
   logic         timeout_q, timeout_d;

   logic inc_min, inc_sec, dec, clr;
   logic is_zero, is_one;

   bcd_mmss_counter #(.MAX_MIN10(MAX_MIN10)) u_counter (
      .clk     (clk),
      .reset_p (reset_p),
      .inc_min (inc_min),
      .inc_sec (inc_sec),
      .dec     (dec),
      .clr     (clr),
      .min10   (min10),
      .min1    (min1),
      .sec10   (sec10),
      .sec1    (sec1),
      .is_zero (is_zero),
      .is_one  (is_one)
   );

   // Next state, counter strobes and registered-output values; clear > start > clk_sec > set buttons.
   always_comb begin
      state_d     = state_q;
      alarm_cnt_d = alarm_cnt_q;
      timeout_d   = 1'b0;
      inc_min     = 1'b0;
      inc_sec     = 1'b0;
      dec         = 1'b0;
      clr         = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_clear) begin
               clr = 1'b1;
            end else if (btn_start) begin
               if (!is_zero) state_d = RUN;
            end else begin
               inc_min = btn_min;
               inc_sec = btn_sec;
            end
         end
         RUN: begin
            if (btn_clear) begin
               clr     = 1'b1;
               state_d = IDLE;
            end else if (btn_start) begin
               state_d = PAUSE;
            end else if (clk_sec) begin
               dec = 1'b1;
               if (is_one) begin
                  state_d     = ALARM;
                  timeout_d   = 1'b1;
                  alarm_cnt_d = 6'd0;
               end
            end
         end
         PAUSE: begin
            if (btn_clear) begin
               clr     = 1'b1;
               state_d = IDLE;
            end else if (btn_start) begin
               state_d = RUN;
            end
         end
         ALARM: begin
            if (btn_clear || btn_start) begin
               clr         = btn_clear;
               state_d     = IDLE;
               alarm_cnt_d = 6'd0;
            end else if (clk_sec) begin
               if (alarm_cnt_q + 6'd1 >= ALARM_LAST) begin
                  state_d     = IDLE;
                  alarm_cnt_d = 6'd0;
               end else begin
                  alarm_cnt_d = alarm_cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            alarm_cnt_d = 6'd0;
         end
      endcase
      running_d = (state_d == RUN);
      alarm_d   = (state_d == ALARM);
   end

   // State, alarm counter and output registers.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q     <= IDLE;
         alarm_cnt_q <= 6'd0;
         running_q   <= 1'b0;
         alarm_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         alarm_cnt_q <= alarm_cnt_d;
         running_q   <= running_d;
         alarm_q     <= alarm_d;
         timeout_q   <= timeout_d;
      end
   end

   assign running = running_q;
   assign alarm   = alarm_q;
   assign timeout = timeout_q;

endmodule
